// File: rtl/rip_lsu.sv
// rip_lsu: single-outstanding load/store unit driving the byte-addressed data memory port.
// Define RIP_LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of force-aligning them.
module rip_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_busy,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic we_q;
  logic bad_f3, bad;
  logic [ADDR_WIDTH-1:0] addr_al;
  logic [DATA_WIDTH-1:0] din_m, rext;
  always_comb begin
    bad_f3 = req_we ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                    : (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110);
`ifdef RIP_LSU_MISALIGN_TRAP_EN
    bad = bad_f3 || (req_funct3[1:0] == 2'b01 && req_addr[0])
                 || (req_funct3[1:0] == 2'b10 && |req_addr[1:0]);
    addr_al = req_addr;
`else
    bad = bad_f3;
    addr_al = req_funct3[1:0] == 2'b10 ? {req_addr[ADDR_WIDTH-1:2], 2'b00}
            : req_funct3[1:0] == 2'b01 ? {req_addr[ADDR_WIDTH-1:1], 1'b0}
            : req_addr;
`endif
    din_m = req_funct3[1:0] == 2'b00 ? {{(DATA_WIDTH-8){1'b0}}, req_wdata[7:0]}
          : req_funct3[1:0] == 2'b01 ? {{(DATA_WIDTH-16){1'b0}}, req_wdata[15:0]}
          : req_wdata;
    // funct3[2] selects the unsigned variants, so it gates the sign bit
    rext = mem_funct3[1:0] == 2'b00 ? {{(DATA_WIDTH-8){mem_dout[7] & ~mem_funct3[2]}}, mem_dout[7:0]}
         : mem_funct3[1:0] == 2'b01 ? {{(DATA_WIDTH-16){mem_dout[15] & ~mem_funct3[2]}}, mem_dout[15:0]}
         : mem_dout;
  end
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign rsp_valid = state == RESP;
  assign mem_re    = state == ISSUE && !mem_busy && !we_q;
  assign mem_we    = state == ISSUE && !mem_busy && we_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      mem_funct3 <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q       <= req_we;
          mem_funct3 <= req_funct3;
          mem_addr   <= addr_al;
          mem_din    <= din_m;
          rsp_err    <= bad;
          rsp_rdata  <= '0;
          state      <= bad ? RESP : ISSUE;
        end
        ISSUE: if (!mem_busy) state <= WAIT;
        WAIT: if (!mem_busy) begin
          rsp_rdata <= we_q ? '0 : rext;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state     <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_rip_lsu.sv
// tb_rip_lsu: randomized load/store transactions checked against an arithmetic reference model.
module tb_rip_lsu;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_we = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic rsp_valid, rsp_ready = 0, rsp_err;
  logic [31:0] rsp_rdata;
  logic mem_we, mem_re;
  logic [2:0] mem_funct3;
  logic [31:0] mem_addr, mem_din, mem_dout = 0;
  logic mem_busy = 0, busy;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  rip_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wdata,
                     input bit [31:0] dout, input int bi, input int bw, input int rd);
    bit bad;
    longint n, v, span;
    bit [31:0] ea, ed, er;
    n = longint'(1) << f3[1:0];
    span = longint'(1) << (8 * n);
    bad = we ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7);
`ifdef RIP_LSU_MISALIGN_TRAP_EN
    if (!bad && longint'(addr) % n != 0) bad = 1;
    ea = addr;
`else
    ea = 32'(longint'(addr) - longint'(addr) % n);
`endif
    ed = 32'(longint'(wdata) % span);
    v = longint'(dout) % span;
    if (!f3[2] && n < 4 && v >= span / 2) v -= span;
    er = (we || bad) ? 32'd0 : 32'(v);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_busy = bi > 0;
    #1;
    chk("accept_ready", req_ready, 1);
    step;
    req_valid = 0; req_wdata = $urandom; req_addr = $urandom;
    if (!bad) begin
      for (int i = 0; i < bi; i++) begin
        mem_busy = 1; #1;
        chk("issue_hold", {mem_re, mem_we, rsp_valid}, 0);
        step;
      end
      mem_busy = 0; #1;
      chk("strobe", {mem_re, mem_we}, {!we, we});
      chk("mem_addr", mem_addr, ea);
      chk("mem_funct3", mem_funct3, f3);
      if (we) chk("mem_din", mem_din, ed);
      step;
      for (int i = 0; i < bw; i++) begin
        mem_busy = 1; mem_dout = $urandom; #1;
        chk("wait_hold", {mem_re, mem_we, rsp_valid}, 0);
        step;
      end
      mem_busy = 0; mem_dout = dout; #1;
      chk("wait_nostrobe", {mem_re, mem_we, rsp_valid}, 0);
      step;
    end
    mem_dout = $urandom;
    #1;
    chk("rsp", {rsp_valid, rsp_err, mem_re, mem_we, rsp_rdata}, {1'b1, bad, 2'b00, er});
    for (int i = 0; i < rd; i++) begin
      rsp_ready = 0; req_valid = 1; req_we = $urandom; req_funct3 = 3'd2;
      step;
      chk("rsp_hold", {rsp_valid, req_ready, rsp_err, rsp_rdata}, {2'b10, bad, er});
    end
    req_valid = 0; rsp_ready = 1;
    step;
    rsp_ready = 0; #1;
    chk("back_idle", {rsp_valid, req_ready, busy, mem_re, mem_we}, 5'b01000);
  endtask
  initial begin
    step; step;
    chk("reset_ctl", {req_ready, rsp_valid, rsp_err, mem_we, mem_re, busy}, 6'b100000);
    chk("reset_data", {rsp_rdata, mem_addr}, 64'd0);
    chk("reset_din_f3", {mem_din, 29'd0, mem_funct3}, 64'd0);
    rst = 0;
    step;
    txn(0, 3'b000, 32'h100, 0, 32'h000000F3, 0, 0, 0);
    txn(0, 3'b101, 32'h102, 0, 32'h0000ABCD, 0, 0, 0);
    txn(0, 3'b001, 32'h102, 0, 32'h0000ABCD, 0, 0, 0);
    txn(1, 3'b000, 32'h200, 32'h12345678, 0, 3, 0, 0);
    txn(0, 3'b010, 32'h103, 0, 32'hCAFEF00D, 0, 0, 0);
    txn(0, 3'b010, 32'h40, 0, 32'hDEADBEEF, 0, 0, 5);
    txn(1, 3'b001, 32'h301, 32'hFFFF8765, 0, 1, 2, 1);
    txn(0, 3'b100, 32'h7, 0, 32'hFFFFFF80, 0, 1, 0);
    txn(0, 3'b111, 32'h10, 0, 32'h1, 0, 0, 2);
    txn(1, 3'b100, 32'h10, 32'h1, 0, 0, 0, 0);
    for (int k = 0; k < 60; k++)
      txn($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    // abort from WAIT: reset is asynchronous, so outputs drop before the next edge
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h10;
    step;
    req_valid = 0; mem_busy = 0;
    step;
    mem_busy = 1;
    step;
    chk("pre_abort_busy", busy, 1);
    rst = 1; #1;
    chk("abort", {busy, mem_re, rsp_valid}, 0);
    step;
    rst = 0; mem_busy = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("post_abort", {rsp_valid, req_ready, busy}, 3'b010);
    end
    txn(0, 3'b000, 32'h55, 0, 32'h7F, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
